uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Frame-level round-robin arbiter sharing one uart TX FIFO write port among NumClients byte-stream clients.
//  Each client presents frames (valid/ready bytes, last marks the final byte).
//  The arbiter grants one client per frame, optionally prepends a header byte carrying the client id, and
//  drives the uart i_tx_req/i_tx_data/o_tx_rdy handshake. It sits between client logic and the uart top level.
// PARAMETERS
//  NumClients    4      number of requesting clients (>=2)
//  DataLength    8      byte width; must match uart DataLength
//  AddHeader     1      1: emit header byte before each frame; 0: payload only
//  HeaderBase    8'hA0  header = HeaderBase | id; low IdWidth bits of HeaderBase must be 0
//  StallTimeout  1024   max consecutive granted-client valid-low cycles in DATA before abort (>=2)
//  IdWidth       $clog2(NumClients) (localparam, min 1)
// PORTS
//  i_clk         in   1                     system clock
//  i_rst         in   1                     synchronous active-high reset
//  i_cl_valid    in   NumClients            per-client byte valid
//  i_cl_data     in   NumClients*DataLength client bytes, client k at [k*DataLength +: DataLength]
//  i_cl_last     in   NumClients            per-client last-byte-of-frame flag, qualified by valid
//  o_cl_ready    out  NumClients            per-client byte accepted this cycle when valid&ready
//  o_tx_req      out  1                     to uart i_tx_req
//  o_tx_data     out  DataLength            to uart i_tx_data
//  i_tx_rdy      in   1                     from uart o_tx_rdy; write occurs on posedge with o_tx_req&i_tx_rdy
//  o_busy        out  1                     frame in progress (state != IDLE)
//  o_gnt_id      out  IdWidth               currently granted client, 0 when IDLE
//  o_abort       out  1                     1-cycle pulse: granted frame aborted by stall timeout
// BEHAVIOUR
//  - Reset (sync, i_rst=1 at posedge): state=IDLE, rr pointer=0, stall counter=0, o_abort=0.
//    All outputs 0 while in IDLE. Reset mid-frame truncates the frame; bytes already in the uart FIFO are
//    not recalled.
//  - States: IDLE, HDR, DATA.
//  - IDLE: if any i_cl_valid, pick first valid client searching from rr pointer upward with wrap
//    (NumClients-1 -> 0). Register it as gnt and go to HDR (AddHeader=1) or DATA.
//    Grant appears the cycle after valid is seen. No bytes are accepted in IDLE.
//  - HDR: o_tx_req=1, o_tx_data=HeaderBase|gnt, all o_cl_ready=0. On i_tx_rdy go to DATA; otherwise hold.
//  - DATA (combinational pass-through, zero added latency):
//      o_tx_req=i_cl_valid[gnt]; o_tx_data=i_cl_data[gnt]; o_cl_ready[gnt]=i_tx_rdy; other readys 0.
//      Transfer = i_cl_valid[gnt]&i_tx_rdy.
//      Transfer with i_cl_last[gnt] -> IDLE; rr pointer=gnt+1 mod NumClients.
//      A single-byte frame (last on first byte) is legal.
//  - Stall counter: in DATA, increments on each cycle with i_cl_valid[gnt]=0; clears on valid or on state change.
//    i_tx_rdy=0 backpressure never counts.
//    Counter reaching StallTimeout-1 with valid still low -> IDLE, o_abort=1 for one cycle, rr pointer=gnt+1.
//  - Fairness: a continuously requesting client waits at most NumClients-1 frames.
//  - Non-granted clients' valid/data/last are ignored; they must hold valid until ready (AXI-style).
//    Changing data while valid&!ready is a client protocol error and is not checked.
//  - Simultaneous: a new request in the same cycle as last transfer is not granted until the next IDLE cycle
//    (1 bubble cycle per frame).
// STRUCTURE
//  - uart_arb_pkg: typedef enum logic [1:0] {IDLE,HDR,DATA} arb_state_t; header/ID helper function.
//  - Sub-module uart_rr_picker: combinational round-robin first-one search (req vector, pointer -> onehot+id+any).
//    Instantiated once.
//  - Top: state register, gnt/pointer registers, stall counter ($clog2(StallTimeout) bits), output mux.
// TESTING (uart stub with controllable i_tx_rdy, plus one run against real uart + serial checker)
//  1. Client 2 sends frame {11,22,33}, i_tx_rdy=1:
//     writes A2,11,22,33 in 4 consecutive cycles; o_busy drops after 33.
//  2. Clients 0,1,3 each hold 2-byte frames from same cycle, pointer=0:
//     frame order 0,1,3,0...; headers A0,A1,A3; 1 bubble between frames.
//  3. i_tx_rdy=0 for 50 cycles mid-frame: o_tx_req held, data stable, no extra writes, no abort.
//     Frame completes after rdy returns.
//  4. StallTimeout=16, client 1 drops valid after 1 byte:
//     o_abort pulses exactly once 16 cycles later, state IDLE, next grant goes to client 2 if requesting.
//  5. i_rst asserted 1 cycle mid-DATA:
//     next cycle o_tx_req=0, o_busy=0, o_gnt_id=0; client 0 then granted first.
//  6. AddHeader=0, single-byte frame 5A with last from client 3: exactly one write of 5A, no header.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the uart TX frame arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Header is the base pattern with the client id OR'd into its zero low bits.
    function automatic logic [31:0] hdr_word(input logic [31:0] base, input logic [31:0] id);
        return base | id;
    endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin search: first set request at or above ptr_i, wrapping to 0.
module uart_rr_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  onehot_o,
    output logic [IW-1:0] id_o,
    output logic          any_o
);

    always_comb begin
        onehot_o = '0;
        id_o     = '0;
        any_o    = 1'b0;
        // Scan farthest offset first so the nearest request overwrites and wins.
        for (int off = N - 1; off >= 0; off--) begin
            if (req_i[(int'(ptr_i) + off) % N]) begin
                onehot_o = '0;
                onehot_o[(int'(ptr_i) + off) % N] = 1'b1;
                id_o  = IW'((int'(ptr_i) + off) % N);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-level round-robin arbiter feeding one uart TX FIFO write port from several byte-stream clients,
// optionally prefixing each frame with a client-id header byte.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int                    NumClients   = 4,
    parameter int                    DataLength   = 8,
    parameter int                    AddHeader    = 1,
    parameter logic [DataLength-1:0] HeaderBase   = DataLength'(8'hA0),
    parameter int                    StallTimeout = 1024,
    localparam int                   IdWidth      = id_width(NumClients)
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [NumClients-1:0]            i_cl_valid,
    input  logic [NumClients*DataLength-1:0] i_cl_data,
    input  logic [NumClients-1:0]            i_cl_last,
    output logic [NumClients-1:0]            o_cl_ready,
    output logic                             o_tx_req,
    output logic [DataLength-1:0]            o_tx_data,
    input  logic                             i_tx_rdy,
    output logic                             o_busy,
    output logic [IdWidth-1:0]               o_gnt_id,
    output logic                             o_abort
);

    localparam int                 CntW   = $clog2(StallTimeout);
    localparam logic [IdWidth-1:0] LastId = IdWidth'(NumClients - 1);
    localparam logic [CntW-1:0]    CntMax = CntW'(StallTimeout - 1);

    arb_state_t            state_q, state_d;
    logic [IdWidth-1:0]    gnt_q, gnt_d;
    logic [IdWidth-1:0]    ptr_q, ptr_d;
    logic [NumClients-1:0] gnt_oh_q, gnt_oh_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  abort_q, abort_d;

    logic [NumClients-1:0] pick_oh;
    logic [IdWidth-1:0]    pick_id;
    logic                  pick_any;

    uart_rr_picker #(
        .N  (NumClients),
        .IW (IdWidth)
    ) u_picker (
        .req_i    (i_cl_valid),
        .ptr_i    (ptr_q),
        .onehot_o (pick_oh),
        .id_o     (pick_id),
        .any_o    (pick_any)
    );

    logic                  g_valid, g_last;
    logic [DataLength-1:0] g_data, hdr_byte;
    logic [IdWidth-1:0]    gnt_inc;

    assign g_valid  = i_cl_valid[gnt_q];
    assign g_last   = i_cl_last[gnt_q];
    assign g_data   = i_cl_data[int'(gnt_q) * DataLength +: DataLength];
    assign hdr_byte = DataLength'(hdr_word(32'(HeaderBase), 32'(gnt_q)));
    assign gnt_inc  = (gnt_q == LastId) ? '0 : gnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_oh_d   = gnt_oh_q;
        ptr_d      = ptr_q;
        cnt_d      = '0;
        abort_d    = 1'b0;
        o_tx_req   = 1'b0;
        o_tx_data  = '0;
        o_cl_ready = '0;
        unique case (state_q)
            IDLE: begin
                gnt_d    = '0;
                gnt_oh_d = '0;
                if (pick_any) begin
                    gnt_d    = pick_id;
                    gnt_oh_d = pick_oh;
                    state_d  = (AddHeader != 0) ? HDR : DATA;
                end
            end
            HDR: begin
                o_tx_req  = 1'b1;
                o_tx_data = hdr_byte;
                if (i_tx_rdy) state_d = DATA;
            end
            DATA: begin
                o_tx_req   = g_valid;
                o_tx_data  = g_data;
                o_cl_ready = gnt_oh_q & {NumClients{i_tx_rdy}};
                // Only a silent client counts toward the stall; uart backpressure never does.
                if (g_valid) begin
                    if (i_tx_rdy && g_last) begin
                        state_d  = IDLE;
                        ptr_d    = gnt_inc;
                        gnt_d    = '0;
                        gnt_oh_d = '0;
                    end
                end else if (cnt_q == CntMax) begin
                    state_d  = IDLE;
                    ptr_d    = gnt_inc;
                    gnt_d    = '0;
                    gnt_oh_d = '0;
                    abort_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            gnt_oh_q <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_oh_q <= gnt_oh_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            abort_q  <= abort_d;
        end
    end

    assign o_busy   = (state_q != IDLE);
    assign o_gnt_id = gnt_q;
    assign o_abort  = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: queue-based client model drives the arbiter; uart write log is checked against hand values.
module tb_uart_tx_arbiter;

    localparam int NC = 4;
    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              rst, tx_rdy;
    logic [NC-1:0]     cl_valid, cl_last, cl_ready;
    logic [NC*DW-1:0]  cl_data;
    logic              tx_req, busy, abort;
    logic [DW-1:0]     tx_data;
    logic [1:0]        gnt_id;

    logic [NC-1:0]     c2_valid, c2_last, c2_ready, c2_pend;
    logic [NC*DW-1:0]  c2_data;
    logic              tx2_req, busy2, abort2;
    logic [DW-1:0]     tx2_data;
    logic [1:0]        gnt2;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.StallTimeout(16)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_cl_valid(cl_valid), .i_cl_data(cl_data), .i_cl_last(cl_last),
        .o_cl_ready(cl_ready), .o_tx_req(tx_req), .o_tx_data(tx_data), .i_tx_rdy(tx_rdy),
        .o_busy(busy), .o_gnt_id(gnt_id), .o_abort(abort)
    );

    uart_tx_arbiter #(.AddHeader(0), .StallTimeout(16)) u_dut_nohdr (
        .i_clk(clk), .i_rst(rst), .i_cl_valid(c2_valid), .i_cl_data(c2_data), .i_cl_last(c2_last),
        .o_cl_ready(c2_ready), .o_tx_req(tx2_req), .o_tx_data(tx2_data), .i_tx_rdy(tx_rdy),
        .o_busy(busy2), .o_gnt_id(gnt2), .o_abort(abort2)
    );

    logic [DW:0]   cbuf [NC][16];
    int            head [NC];
    int            tail [NC];
    logic [NC-1:0] hold;
    logic          rst_nxt, rdy_nxt;
    logic [DW-1:0] wlog[$];
    int            wcyc[$];
    logic [DW-1:0] wlog2[$];
    int            cyc = 0, nchk = 0, nerr = 0, n_abort = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int k, input logic [DW-1:0] d, input logic l);
        cbuf[k][tail[k]] = {l, d};
        tail[k]++;
    endtask

    task automatic flush();
        for (int k = 0; k < NC; k++) begin
            head[k] = 0;
            tail[k] = 0;
            for (int j = 0; j < 16; j++) cbuf[k][j] = '0;
        end
    endtask

    // Drive on negedge, then log what the coming posedge will commit.
    task automatic tick();
        @(negedge clk);
        rst    = rst_nxt;
        tx_rdy = rdy_nxt;
        for (int k = 0; k < NC; k++) begin
            cl_valid[k]         = (head[k] != tail[k]) && !hold[k];
            cl_data[k*DW +: DW] = cbuf[k][head[k] % 16][DW-1:0];
            cl_last[k]          = cbuf[k][head[k] % 16][DW];
        end
        c2_valid = c2_pend;
        #2;
        cyc++;
        if (tx_req && tx_rdy) begin
            wlog.push_back(tx_data);
            wcyc.push_back(cyc);
        end
        if (tx2_req && tx_rdy) wlog2.push_back(tx2_data);
        if (abort) n_abort++;
        for (int k = 0; k < NC; k++) begin
            if (cl_valid[k] && cl_ready[k]) head[k]++;
            if (c2_valid[k] && c2_ready[k]) c2_pend[k] = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] exp2 [12];
        int t0, k, bad;
        logic got;

        rst = 1'b1; tx_rdy = 1'b1; rst_nxt = 1'b1; rdy_nxt = 1'b1;
        cl_valid = '0; cl_last = '0; cl_data = '0; hold = '0;
        c2_valid = '0; c2_last = '0; c2_data = '0; c2_pend = '0;
        flush();

        // Reset state
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_req", tx_req, 0);
        chk("rst_gnt", gnt_id, 0);
        chk("rst_abort", abort, 0);
        chk("rst_ready", cl_ready, 0);
        rst_nxt = 1'b0;

        // 1: client 2 frame {11,22,33}
        t0 = cyc;
        push(2, 8'h11, 0); push(2, 8'h22, 0); push(2, 8'h33, 1);
        repeat (5) tick();
        chk("t1_busy_last", busy, 1);
        tick();
        chk("t1_busy_done", busy, 0);
        chk("t1_nwr", wlog.size(), 4);
        chk("t1_w0", wlog[0], 8'hA2);
        chk("t1_w1", wlog[1], 8'h11);
        chk("t1_w2", wlog[2], 8'h22);
        chk("t1_w3", wlog[3], 8'h33);
        chk("t1_first_cyc", wcyc[0], t0 + 2);
        chk("t1_last_cyc", wcyc[3], t0 + 5);

        // 2: clients 0,1,3 contend from pointer 0
        rst_nxt = 1'b1; tick(); rst_nxt = 1'b0;
        flush(); wlog.delete(); wcyc.delete();
        push(0, 8'h01, 0); push(0, 8'h02, 1); push(0, 8'h03, 0); push(0, 8'h04, 1);
        push(1, 8'h11, 0); push(1, 8'h12, 1);
        push(3, 8'h31, 0); push(3, 8'h32, 1);
        repeat (20) tick();
        exp2 = '{8'hA0, 8'h01, 8'h02, 8'hA1, 8'h11, 8'h12, 8'hA3, 8'h31, 8'h32, 8'hA0, 8'h03, 8'h04};
        chk("t2_nwr", wlog.size(), 12);
        for (int i = 0; i < 12; i++) chk($sformatf("t2_w%0d", i), wlog[i], exp2[i]);
        for (int f = 0; f < 3; f++) chk($sformatf("t2_gap%0d", f), wcyc[3*f+3] - wcyc[3*f], 4);
        chk("t2_idle", busy, 0);

        // 3: 50 cycles of uart backpressure mid-frame
        wlog.delete(); wcyc.delete(); n_abort = 0;
        push(0, 8'hC1, 0); push(0, 8'hC2, 0); push(0, 8'hC3, 1);
        k = 0;
        while (wlog.size() < 2 && k < 10) begin tick(); k++; end
        chk("t3_pre_nwr", wlog.size(), 2);
        rdy_nxt = 1'b0; bad = 0;
        repeat (50) begin
            tick();
            if (tx_req !== 1'b1 || tx_data !== 8'hC2 || abort !== 1'b0) bad++;
        end
        chk("t3_hold_bad", bad, 0);
        chk("t3_hold_nwr", wlog.size(), 2);
        rdy_nxt = 1'b1;
        repeat (4) tick();
        chk("t3_nwr", wlog.size(), 4);
        chk("t3_w0", wlog[0], 8'hA0);
        chk("t3_w2", wlog[2], 8'hC2);
        chk("t3_w3", wlog[3], 8'hC3);
        chk("t3_no_abort", n_abort, 0);
        chk("t3_idle", busy, 0);

        // 4: client 1 stalls after first byte, client 2 waiting
        wlog.delete(); wcyc.delete(); n_abort = 0;
        push(1, 8'hD1, 0); push(1, 8'hD2, 1); push(2, 8'hE1, 1);
        k = 0;
        while (wlog.size() < 2 && k < 10) begin tick(); k++; end
        chk("t4_pre_w1", wlog[1], 8'hD1);
        hold[1] = 1'b1;
        k = 0; got = 1'b0;
        while (!got && k < 40) begin
            tick(); k++;
            if (abort) got = 1'b1;
        end
        chk("t4_abort_lat", k, 17);
        chk("t4_abort_busy", busy, 0);
        chk("t4_abort_gnt", gnt_id, 0);
        tick();
        chk("t4_abort_pulse", abort, 0);
        chk("t4_next_gnt", gnt_id, 2);
        chk("t4_next_hdr", tx_data, 8'hA2);
        repeat (4) tick();
        chk("t4_abort_once", n_abort, 1);
        chk("t4_w3", wlog[3], 8'hE1);
        flush(); hold = '0;

        // 5: reset pulse mid-DATA
        wlog.delete(); wcyc.delete();
        push(3, 8'hF1, 0); push(3, 8'hF2, 0); push(3, 8'hF3, 1);
        k = 0;
        while (wlog.size() < 2 && k < 10) begin tick(); k++; end
        chk("t5_pre_hdr", wlog[0], 8'hA3);
        rst_nxt = 1'b1;
        push(0, 8'h5C, 1);
        tick();
        rst_nxt = 1'b0;
        tick();
        chk("t5_req", tx_req, 0);
        chk("t5_busy", busy, 0);
        chk("t5_gnt", gnt_id, 0);
        tick();
        chk("t5_regnt", gnt_id, 0);
        chk("t5_hdr", tx_data, 8'hA0);
        repeat (10) tick();
        flush();
        repeat (2) tick();

        // 6: no-header instance, single-byte frame from client 3
        wlog2.delete();
        c2_data[3*DW +: DW] = 8'h5A;
        c2_last = 4'b1000;
        c2_pend = 4'b1000;
        repeat (6) tick();
        chk("t6_nwr", wlog2.size(), 1);
        chk("t6_w0", wlog2[0], 8'h5A);
        chk("t6_busy", busy2, 0);
        chk("t6_gnt", gnt2, 0);
        chk("t6_abort", abort2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
